// File: rtl/demux1to8_frame_pkg.sv
// Shared lane geometry and frame-state encoding for the 1-to-8 frame demultiplexer.
package demux_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        FILL,
        HOLD
    } demux_state_t;

endpackage

// File: rtl/demux1to8_frame_if.sv
// Word-in / frame-out bus of the 1-to-8 frame demultiplexer.
interface demux1to8_frame_if #(
    parameter int WIDTH = 8
);
    import demux_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_auto;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_e;
    logic [WIDTH-1:0] out_f;
    logic [WIDTH-1:0] out_g;
    logic [WIDTH-1:0] out_h;
    logic [LANES-1:0] lane_valid;
    logic [SEL_W-1:0] cur_lane;
    logic             frame_valid;
    logic             frame_ack;

    modport slave (
        input  in_data, in_sel, in_auto, in_valid, frame_ack,
        output in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
        output lane_valid, cur_lane, frame_valid
    );

    modport master (
        output in_data, in_sel, in_auto, in_valid, frame_ack,
        input  in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
        input  lane_valid, cur_lane, frame_valid
    );

endinterface

// File: rtl/demux1to8_frame_lane_decoder.sv
// 3-to-8 one-hot decoder with enable; produces the lane write strobes.
module demux_lane_decoder
    import demux_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1to8_frame.sv
// Registered 1-to-8 demultiplexer/deserializer: fills eight lane registers, then holds the frame until acked.
module demux1to8_frame
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    demux1to8_frame_if.slave       bus
);

    demux_state_t     state;
    logic [WIDTH-1:0] lanes [LANES];
    logic [LANES-1:0] lane_valid;
    logic [SEL_W-1:0] cur_lane;
    logic [SEL_W-1:0] lane_sel;
    logic [LANES-1:0] strobe;
    logic             transfer;

    assign transfer = bus.in_valid && (state == FILL);
    assign lane_sel = bus.in_auto ? cur_lane : bus.in_sel;

    demux_lane_decoder u_decoder (
        .en     (transfer),
        .sel    (lane_sel),
        .onehot (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            lane_valid <= '0;
            cur_lane   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (transfer) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (strobe[i]) begin
                                lanes[i] <= bus.in_data;
                            end
                        end
                        lane_valid <= lane_valid | strobe;
                        if (bus.in_auto) begin
                            cur_lane <= cur_lane + 1'b1;
                        end
                        // Completion looks at the post-write mask, so the last lane closes the frame this edge.
                        if ((lane_valid | strobe) == '1) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        lane_valid <= '0;
                        cur_lane   <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready    = (state == FILL);
    assign bus.frame_valid = (state == HOLD);
    assign bus.lane_valid  = lane_valid;
    assign bus.cur_lane    = cur_lane;
    assign bus.out_a       = lanes[0];
    assign bus.out_b       = lanes[1];
    assign bus.out_c       = lanes[2];
    assign bus.out_d       = lanes[3];
    assign bus.out_e       = lanes[4];
    assign bus.out_f       = lanes[5];
    assign bus.out_g       = lanes[6];
    assign bus.out_h       = lanes[7];

endmodule

// File: tb/tb_demux1to8_frame.sv
// Self-checking bench for demux1to8_frame: directed scenarios plus randomized traffic against a frame-level model.
module tb_demux1to8_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux1to8_frame_if #(.WIDTH(8)) bus ();

    demux1to8_frame #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lane contents, written-lane set, auto counter, frame-held flag.
    logic [7:0] m_lane [8];
    logic [7:0] m_valid;
    int         m_cur;
    bit         m_hold;

    logic [7:0] scen2_words [8];

    function automatic logic [7:0] dut_lane(input int idx);
        case (idx)
            0: return bus.out_a;
            1: return bus.out_b;
            2: return bus.out_c;
            3: return bus.out_d;
            4: return bus.out_e;
            5: return bus.out_f;
            6: return bus.out_g;
            default: return bus.out_h;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s lane%0d", tag, i), 32'(dut_lane(i)), 32'(m_lane[i]));
        end
        check({tag, " lane_valid"}, 32'(bus.lane_valid), 32'(m_valid));
        check({tag, " cur_lane"}, 32'(bus.cur_lane), 32'(m_cur));
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(!m_hold));
        check({tag, " frame_valid"}, 32'(bus.frame_valid), 32'(m_hold));
    endtask

    task automatic model_edge(input bit r, input bit v, input bit a, input int s,
                              input logic [7:0] d, input bit k);
        int l;
        if (r) begin
            for (int i = 0; i < 8; i++) m_lane[i] = 8'h00;
            m_valid = 8'h00;
            m_cur   = 0;
            m_hold  = 0;
        end else if (!m_hold) begin
            if (v) begin
                l = a ? m_cur : s;
                m_lane[l] = d;
                m_valid   = m_valid | (8'h01 << l);
                if (a) m_cur = (m_cur + 1) % 8;
                if (m_valid == 8'hFF) m_hold = 1;
            end
        end else if (k) begin
            m_valid = 8'h00;
            m_cur   = 0;
            m_hold  = 0;
        end
    endtask

    // One clock: drive, advance the model, sample 1 time unit after the edge.
    task automatic step(input string tag, input bit r, input bit v, input bit a, input int s,
                        input logic [7:0] d, input bit k);
        rst           = r;
        bus.in_valid  = v;
        bus.in_auto   = a;
        bus.in_sel    = 3'(s);
        bus.in_data   = d;
        bus.frame_ack = k;
        model_edge(r, v, a, s, d, k);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_auto   = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.frame_ack = 1'b0;
        for (int i = 0; i < 8; i++) m_lane[i] = 8'hXX;
        scen2_words[0] = 8'hA0; scen2_words[1] = 8'hB1;
        scen2_words[2] = 8'hC2; scen2_words[3] = 8'hD3;
        scen2_words[4] = 8'hE4; scen2_words[5] = 8'hF5;
        scen2_words[6] = 8'h16; scen2_words[7] = 8'h27;

        // Reset held for two cycles
        step("rst1", 1, 0, 0, 0, 8'h00, 0);
        step("rst2", 1, 0, 0, 0, 8'h00, 0);
        check("rst lane_valid const", 32'(bus.lane_valid), 32'h00);
        check("rst in_ready const", 32'(bus.in_ready), 32'h1);

        // Auto-mode fill, back-to-back
        for (int i = 0; i < 8; i++) begin
            step($sformatf("auto%0d", i), 0, 1, 1, 0, scen2_words[i], 0);
        end
        check("fill frame_valid const", 32'(bus.frame_valid), 32'h1);
        check("fill in_ready const", 32'(bus.in_ready), 32'h0);
        check("fill cur_lane const", 32'(bus.cur_lane), 32'h0);

        // Loopback through an 8:1 selection of the lane outputs
        for (int s = 0; s < 8; s++) begin
            check($sformatf("loopback S=%0d", s), 32'(dut_lane(s)), 32'(scen2_words[s]));
        end

        // HOLD ignores writes; ack releases with in_valid still high
        step("hold_wr", 0, 1, 0, 2, 8'hFF, 0);
        step("hold_wr_auto", 0, 1, 1, 0, 8'hFF, 0);
        step("ack", 0, 1, 0, 3, 8'hFF, 1);
        check("ack lane_valid const", 32'(bus.lane_valid), 32'h00);
        check("ack out_d kept", 32'(bus.out_d), 32'hD3);
        step("post_ack_idle", 0, 0, 0, 0, 8'h00, 0);

        // Addressed write and overwrite of the same lane
        step("sel5_a", 0, 1, 0, 5, 8'hF5, 0);
        check("sel5 lane_valid const", 32'(bus.lane_valid), 32'h20);
        step("sel5_b", 0, 1, 0, 5, 8'h55, 0);
        check("sel5 overwrite out_f", 32'(bus.out_f), 32'h55);
        check("sel5 still 20", 32'(bus.lane_valid), 32'h20);
        step("ack_in_fill", 0, 0, 0, 0, 8'h00, 1);

        // Partial auto fill interrupted by reset
        step("pre_rst_ack", 1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step($sformatf("part%0d", i), 0, 1, 1, 0, 8'(8'h30 + i), 0);
        step("mid_rst", 1, 1, 1, 0, 8'h99, 0);
        step("after_rst", 0, 1, 1, 0, 8'h6A, 0);
        check("after_rst out_a", 32'(bus.out_a), 32'h6A);

        // Randomized traffic: mixed modes, random acks, rare resets
        for (int n = 0; n < 400; n++) begin
            step($sformatf("rnd%0d", n),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)),
                 8'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
